// File: rtl/tone_sequencer_if.sv
// Bus bundle for tone_sequencer: note-memory write port, playback control,
// volume input and the DAC/status outputs.
//   master : control side (drives writes, start/stop/loop_en, volume)
//   slave  : the sequencer (drives t_on, busy, done, note_idx)
interface tone_sequencer_if #(
  parameter int N  = 8,
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [N-1:0]  volume;
  logic [N-1:0]  t_on;
  logic          busy;
  logic          done;
  logic [AW-1:0] note_idx;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_en, volume,
    input  t_on, busy, done, note_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_en, volume,
    output t_on, busy, done, note_idx
  );
endinterface

// File: rtl/tone_sequencer.sv
// Note sequencer for the PWM DAC. Plays a list of notes held in a small
// flop memory; each note is a square wave of pitch P (half period
// P*2^TONE_SHIFT clk cycles, P=0 is a rest) at amplitude 'volume', lasting
// D*TICK_DIV cycles, followed by a silent gap of GAP_TICKS*TICK_DIV cycles.
// An entry with D=0 ends the list.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus.wr_en/wr_addr/wr_data : note memory write ({P[7:0], D[7:0]})
//   bus.start/stop/loop_en    : playback control
//   bus.volume                : square-wave high level
//   bus.t_on                  : DAC duty value (registered)
//   bus.busy/done/note_idx    : status
module tone_sequencer #(
  parameter int N          = 8,
  parameter int DEPTH      = 16,
  parameter int TICK_DIV   = 1000,
  parameter int TONE_SHIFT = 4,
  parameter int GAP_TICKS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  tone_sequencer_if.slave  bus
);
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW       = (TONE_SHIFT > 0) ? TONE_SHIFT : 1;
  localparam int PLAY_MAX = 255 * TICK_DIV;
  localparam int GAP_LEN  = GAP_TICKS * TICK_DIV;
  localparam int DW       = $clog2(((PLAY_MAX > GAP_LEN) ? PLAY_MAX : GAP_LEN) + 1);

  localparam logic [PW-1:0] PRE_MAX  = PW'((1 << TONE_SHIFT) - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(GAP_LEN - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

  state_t        state, state_n;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   cur;
  logic [7:0]    p_lat, d_lat;
  logic [DW-1:0] dur_cnt, play_end;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    pitch_cnt;
  logic          square;
  logic [N-1:0]  t_on_r;
  logic          busy_r, done_r;
  logic [AW-1:0] idx_r, idx_n;
  logic          done_n;
  logic          adv, fin;

  assign bus.t_on     = t_on_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.note_idx = idx_r;

  // Note memory: no reset, writable at any time. The playing note is
  // protected by the copy taken in FETCH.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  assign cur      = mem[idx_r];
  assign play_end = DW'(d_lat) * DW'(TICK_DIV) - DW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state. 'adv' = current note (incl. gap) finished, step to the next
  // entry; 'fin' = end of list reached. Both resolve in the same cycle, so
  // NEXT and END never cost a clock of their own.
  always_comb begin
    state_n = state;
    idx_n   = idx_r;
    done_n  = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_FETCH;
          idx_n   = '0;
        end
      end
      S_FETCH: begin
        if (cur[7:0] == 8'd0) fin = 1'b1;
        else                  state_n = S_PLAY;
      end
      S_PLAY: begin
        if (dur_cnt == play_end) begin
          if (GAP_TICKS == 0) adv = 1'b1;
          else                state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (dur_cnt == GAP_END) adv = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (adv) begin
      if (idx_r == LAST_IDX) begin
        fin = 1'b1;
      end else begin
        idx_n   = idx_r + AW'(1);
        state_n = S_FETCH;
      end
    end

    if (fin) begin
      idx_n = '0;
      if (bus.loop_en) begin
        state_n = S_FETCH;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end

    // stop overrides every transition, including start and completion
    if (bus.stop) begin
      state_n = S_IDLE;
      idx_n   = '0;
      done_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_on_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      idx_r     <= '0;
      p_lat     <= '0;
      d_lat     <= '0;
      dur_cnt   <= '0;
      pre_cnt   <= '0;
      pitch_cnt <= '0;
      square    <= 1'b0;
    end else begin
      idx_r  <= idx_n;
      busy_r <= (state_n != S_IDLE);
      done_r <= done_n;
      t_on_r <= (state == S_PLAY && square && p_lat != 8'd0) ? bus.volume : '0;

      if (state == S_FETCH) begin
        p_lat <= cur[15:8];
        d_lat <= cur[7:0];
      end

      // Cycle counter for PLAY/GAP; restarts on every state change.
      if (state_n == state && (state == S_PLAY || state == S_GAP))
        dur_cnt <= dur_cnt + DW'(1);
      else
        dur_cnt <= '0;

      // Square generator: held at its note-start phase (high) outside PLAY,
      // so each note begins with a full high half period.
      if (state != S_PLAY) begin
        pre_cnt   <= '0;
        pitch_cnt <= '0;
        square    <= 1'b1;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
        if (pre_cnt == PRE_MAX) begin
          if (pitch_cnt == p_lat - 8'd1) begin
            pitch_cnt <= '0;
            square    <= ~square;
          end else begin
            pitch_cnt <= pitch_cnt + 8'd1;
          end
        end
      end
    end
  end
endmodule
